// File: rtl/arb_pkg.sv
// ============================================================================
//  arb_pkg
//  Shared types, sizes and helpers for the round-robin mux arbiter.
//
//  Contents:
//    NUM_REQ      number of requesters sharing the forward path
//    arb_state_e  arbiter FSM states (IDLE, BUSY)
//    idx2onehot   2-bit requester index -> 4-bit one-hot vector
//    onehot2idx   4-bit one-hot vector  -> 2-bit requester index
//
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Lowest set bit wins; an all-zero vector maps to index 0.
   function automatic logic [1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (oh[k]) begin
            idx = 2'(k);
         end
      end
      return idx;
   endfunction

endpackage : arb_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  rr_pick
//  Combinational next-winner selection for the four-way arbiter.
//  Scans requests starting one position after the last served requester
//  and wraps modulo four.
//
//  Ports:
//    req_i    [3:0]  request vector, bit i = requester i
//    last_i   [1:0]  index of the most recently served requester
//    valid_o         at least one eligible request is present
//    idx_o    [1:0]  index of the winning requester
//
//  Configuration macro:
//    FIXED_PRIO0_EN  requester 0 always wins when requesting; requesters
//                    1..3 rotate among themselves.
//
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import arb_pkg::*;
(
   input  logic [3:0] req_i,
   input  logic [1:0] last_i,
   output logic       valid_o,
   output logic [1:0] idx_o
);

   logic [3:0] w_rr_req;    // requests taking part in the rotating scan
   logic [3:0] w_rr_oh;     // one-hot winner of the rotating scan
   logic       w_rr_found;

`ifdef FIXED_PRIO0_EN
   // Requester 0 is handled outside the rotation, so it is masked here.
   assign w_rr_req = {req_i[3:1], 1'b0};
`else
   assign w_rr_req = req_i;
`endif

   // Walk last+1, last+2, ... (mod 4); the first requesting slot wins.
   always_comb begin
      logic [1:0] w_cand;
      w_rr_oh    = '0;
      w_rr_found = 1'b0;
      w_cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = last_i + 2'(k + 1);
         if (!w_rr_found && w_rr_req[w_cand]) begin
            w_rr_oh[w_cand] = 1'b1;
            w_rr_found      = 1'b1;
         end
      end
   end

`ifdef FIXED_PRIO0_EN
   assign valid_o = req_i[0] | w_rr_found;
   assign idx_o   = req_i[0] ? 2'd0 : onehot2idx(w_rr_oh);
`else
   assign valid_o = w_rr_found;
   assign idx_o   = onehot2idx(w_rr_oh);
`endif

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
//  rr_mux_arbiter
//  Round-robin arbiter sharing one WIDTH-bit forward path among four
//  requesters, with a matching 1:4 return-path route. A grant is held for
//  at most MAX_BEATS accepted beats, then released for one IDLE cycle
//  before the next winner is chosen.
//
//  Parameters:
//    WIDTH      data width of every forward and return bus
//    MAX_BEATS  maximum accepted beats per grant (>= 1)
//
//  Ports:
//    clk, rst                 clock, synchronous active-high reset
//    req          [3:0]       per-requester request
//    in_data0..3  [WIDTH]     forward data from each requester
//    gnt          [3:0]       registered one-hot grant
//    out_valid, out_data      shared forward beat to the consumer
//    out_ready                consumer accepts the current beat
//    rsp_valid, rsp_data      return beat from the consumer
//    rsp_valid_o  [3:0]       return valid routed to the granted requester
//    rsp_data0..3 [WIDTH]     return data per requester
//    busy                     arbiter is in BUSY
//
//  Configuration macro:
//    FIXED_PRIO0_EN  requester 0 has fixed top priority; 1..3 rotate.
//
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_BEATS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic [3:0]       gnt,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             rsp_valid,
   input  logic [WIDTH-1:0] rsp_data,
   output logic [3:0]       rsp_valid_o,
   output logic [WIDTH-1:0] rsp_data0,
   output logic [WIDTH-1:0] rsp_data1,
   output logic [WIDTH-1:0] rsp_data2,
   output logic [WIDTH-1:0] rsp_data3,
   output logic             busy
);

   localparam int             CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

   arb_state_e       state_q;
   logic [3:0]       gnt_q;
   logic [1:0]       sel_q;
   logic [1:0]       last_q;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [CNT_W-1:0] beat_cnt_d;

   logic             w_busy;
   logic             w_req_sel;
   logic             w_xfer;
   logic             w_release;
   logic             w_pick_valid;
   logic [1:0]       w_pick_idx;

   // ------------------------------------------------------------------------
   // Next-winner selection
   // ------------------------------------------------------------------------
   rr_pick u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .valid_o (w_pick_valid),
      .idx_o   (w_pick_idx)
   );

   // ------------------------------------------------------------------------
   // Burst bookkeeping
   // ------------------------------------------------------------------------
   assign w_busy     = (state_q == BUSY);
   assign w_req_sel  = req[sel_q];
   assign w_xfer     = w_busy & w_req_sel & out_ready;
   assign beat_cnt_d = beat_cnt_q + 1'b1;

   // A dropped request releases without counting a beat; otherwise the
   // final permitted transfer releases at the same edge it is accepted.
   assign w_release  = w_busy & (~w_req_sel | (w_xfer & (beat_cnt_q == LAST_BEAT)));

   // ------------------------------------------------------------------------
   // Arbiter FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         sel_q      <= '0;
         beat_cnt_q <= '0;
         last_q     <= 2'd3;     // requester 0 is first after reset
      end else begin
         case (state_q)
            IDLE: begin
               if (w_pick_valid) begin
                  sel_q      <= w_pick_idx;
                  gnt_q      <= idx2onehot(w_pick_idx);
                  beat_cnt_q <= '0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (w_release) begin
`ifdef FIXED_PRIO0_EN
                  // Rotation pointer covers requesters 1..3 only.
                  if (sel_q != 2'd0) begin
                     last_q <= sel_q;
                  end
`else
                  last_q <= sel_q;
`endif
                  gnt_q      <= '0;
                  beat_cnt_q <= '0;
                  state_q    <= IDLE;
               end else if (w_xfer) begin
                  beat_cnt_q <= beat_cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign busy = w_busy;

   // ------------------------------------------------------------------------
   // Forward mux: driven to zero whenever the path is idle
   // ------------------------------------------------------------------------
   assign out_valid = w_busy & w_req_sel;

   always_comb begin
      out_data = '0;
      if (w_busy) begin
         case (sel_q)
            2'd0:    out_data = in_data0;
            2'd1:    out_data = in_data1;
            2'd2:    out_data = in_data2;
            default: out_data = in_data3;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Return demux: only the granted requester sees the consumer response
   // ------------------------------------------------------------------------
   always_comb begin
      rsp_valid_o = '0;
      rsp_data0   = '0;
      rsp_data1   = '0;
      rsp_data2   = '0;
      rsp_data3   = '0;
      if (w_busy) begin
         rsp_valid_o[sel_q] = rsp_valid;
         case (sel_q)
            2'd0:    rsp_data0 = rsp_data;
            2'd1:    rsp_data1 = rsp_data;
            2'd2:    rsp_data2 = rsp_data;
            default: rsp_data3 = rsp_data;
         endcase
      end
   end

endmodule : rr_mux_arbiter

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
//  tb_rr_mux_arbiter
//  Directed self-checking bench for rr_mux_arbiter (WIDTH=4, MAX_BEATS=4).
//  Inputs change and outputs are sampled 1 ns after each rising edge.
//
//  Configuration macro:
//    FIXED_PRIO0_EN  selects the fixed-priority scenario set.
//
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

   localparam int WIDTH     = 4;
   localparam int MAX_BEATS = 4;

   logic             clk;
   logic             rst;
   logic [3:0]       req;
   logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0]       gnt;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic [3:0]       rsp_valid_o;
   logic [WIDTH-1:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
   logic             busy;

   int n_vec;
   int n_err;

   logic [WIDTH-1:0] r_dat [4];   // forward data pattern per requester

   rr_mux_arbiter #(
      .WIDTH     (WIDTH),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .in_data0    (in_data0),
      .in_data1    (in_data1),
      .in_data2    (in_data2),
      .in_data3    (in_data3),
      .gnt         (gnt),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data0   (rsp_data0),
      .rsp_data1   (rsp_data1),
      .rsp_data2   (rsp_data2),
      .rsp_data3   (rsp_data3),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expect an active grant to requester g with its data on the forward path.
   task automatic chk_grant(input string tag, input int g);
      logic [3:0] oh;
      oh = 4'b0001 << g;
      chk({tag, ".gnt"},  32'(gnt), 32'(oh));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".data"}, 32'(out_data), 32'(r_dat[g]));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".gnt"},   32'(gnt), 32'd0);
      chk({tag, ".busy"},  32'(busy), 32'd0);
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".data"},  32'(out_data), 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      r_dat[0] = 4'hA; r_dat[1] = 4'hB; r_dat[2] = 4'hC; r_dat[3] = 4'hD;
      in_data0 = r_dat[0]; in_data1 = r_dat[1];
      in_data2 = r_dat[2]; in_data3 = r_dat[3];
      rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
      rsp_valid = 1'b0; rsp_data = '0;
      tick();
      tick();

      // ---- reset state ------------------------------------------------------
      chk_idle("rst");
      chk("rst.rspv", 32'(rsp_valid_o), 32'd0);
      rst = 1'b0;

`ifndef FIXED_PRIO0_EN
      // ---- single requester, full burst, re-grant after one dead cycle ------
      req = 4'b0001; out_ready = 1'b1;
      tick();
      chk_grant("s1.g0", 0);
      chk("s1.valid", 32'(out_valid), 32'd1);
      for (int b = 1; b < MAX_BEATS; b++) begin
         tick();
         chk_grant($sformatf("s1.b%0d", b), 0);
      end
      tick();
      chk_idle("s1.gap");
      tick();
      chk_grant("s1.regrant", 0);
      req = 4'b0000;
      tick();
      chk_idle("s1.drop");

      // ---- all requesting: rotation 1,2,3,0 after last=0 --------------------
      req = 4'b1111;
      begin
         int order [4];
         order = '{1, 2, 3, 0};
         for (int i = 0; i < 4; i++) begin
            tick();
            chk_grant($sformatf("s2.g%0d", i), order[i]);
            for (int b = 1; b < MAX_BEATS; b++) begin
               tick();
               chk($sformatf("s2.g%0d.hold%0d", i, b), 32'(gnt), 32'(4'b0001 << order[i]));
            end
            tick();
            chk_idle($sformatf("s2.gap%0d", i));
         end
      end
      req = 4'b0000;
      tick();

      // ---- requester 2, stalled beat, request dropped after 2 transfers -----
      req = 4'b0100; out_ready = 1'b1;
      tick();
      chk_grant("s3.g2", 2);
      tick();                  // transfer 1
      out_ready = 1'b0;
      tick();                  // stalled
      chk_grant("s3.stall", 2);
      out_ready = 1'b1;
      tick();                  // transfer 2
      chk_grant("s3.b2", 2);
      req = 4'b1001;           // req2 drops; 3 and 0 waiting
      tick();
      chk_idle("s3.rel");
      tick();
      chk_grant("s3.next3", 3);
      req = 4'b0000;
      tick();

      // ---- return path routing to requester 1, held with out_ready low ------
      req = 4'b0010; out_ready = 1'b0;
      rsp_valid = 1'b1; rsp_data = 4'h5;
      tick();
      chk_grant("s4.g1", 1);
      chk("s4.rspv", 32'(rsp_valid_o), 32'b0010);
      chk("s4.rsp1", 32'(rsp_data1), 32'h5);
      chk("s4.rsp0", 32'(rsp_data0), 32'h0);
      chk("s4.rsp2", 32'(rsp_data2), 32'h0);
      chk("s4.rsp3", 32'(rsp_data3), 32'h0);
      repeat (8) tick();
      chk("s4.persist", 32'(gnt), 32'b0010);
      req = 4'b0000;
      tick();
      chk_idle("s4.idle");
      chk("s4.idle.rspv", 32'(rsp_valid_o), 32'd0);
      chk("s4.idle.rsp1", 32'(rsp_data1), 32'h0);
      rsp_valid = 1'b0; rsp_data = '0;

      // ---- reset mid-burst, then requester 0 wins first ---------------------
      req = 4'b1111; out_ready = 1'b1;
      tick();
      chk_grant("s5.g2", 2);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_idle("s5.rst");
      rst = 1'b0;
      tick();
      chk_grant("s5.after", 0);
      req = 4'b0000;
      tick();
`else
      // ---- fixed priority: req0 raised during a requester 1 burst -----------
      req = 4'b1110; out_ready = 1'b1;
      tick();
      chk_grant("p.g1", 1);
      req = 4'b1111;
      for (int b = 1; b < MAX_BEATS; b++) begin
         tick();
         chk_grant($sformatf("p.b%0d", b), 1);
      end
      tick();
      chk_idle("p.gap");
      tick();
      chk_grant("p.g0", 0);
      for (int b = 1; b < MAX_BEATS; b++) tick();
      tick();
      chk_idle("p.gap0");
      req = 4'b1100;
      tick();
      chk_grant("p.g2", 2);
      req = 4'b0000;
      tick();
      chk_idle("p.end");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_rr_mux_arbiter

`default_nettype wire
